line_buffer: RTL and testbench

// - Fixed-length pixel delay line with a one-bit valid tag travelling alongside each pixel.
// - Sits in the median-filter preparation path. Cascading instances with DEPTH = image width

---
 rtl/line_buffer.sv | 105 ++++++++++
 tb/tb_line_buffer.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/line_buffer.sv
// Fixed-length pixel delay line: each {valid, pixel} pair written in reappears exactly
// DEPTH clocks later. Used to align image rows for the median-filter window.
module line_buffer #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 640
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  done_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  done_o
);

  // Oldest entry as seen this cycle, before this edge overwrites it.
  logic                  rd_vld;
  logic [DATA_WIDTH-1:0] rd_data;

  logic                  done_q, done_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;

  generate
    if (DEPTH == 1) begin : g_single
      logic                  ent_vld_q, ent_vld_d;
      logic [DATA_WIDTH-1:0] ent_data_q, ent_data_d;

      always_comb begin
        ent_vld_d  = done_i;
        ent_data_d = data_i;
      end

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          ent_vld_q  <= 1'b0;
          ent_data_q <= '0;
        end else begin
          ent_vld_q  <= ent_vld_d;
          ent_data_q <= ent_data_d;
        end
      end

      assign rd_vld  = ent_vld_q;
      assign rd_data = ent_data_q;
    end else begin : g_ring
      localparam int PTR_W = $clog2(DEPTH);
      localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

      logic [PTR_W-1:0]      ptr_q, ptr_d;
      logic [DEPTH-1:0]      mem_vld_q;
      logic [DATA_WIDTH-1:0] mem_data_q [DEPTH];
      logic                  wr_vld_d;
      logic [DATA_WIDTH-1:0] wr_data_d;

      // The pointer free-runs: idle cycles occupy slots too, which preserves gaps.
      always_comb begin
        ptr_d     = (ptr_q == PTR_LAST) ? '0 : ptr_q + 1'b1;
        wr_vld_d  = done_i;
        wr_data_d = data_i;
      end

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          ptr_q <= '0;
        end else begin
          ptr_q <= ptr_d;
        end
      end

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          mem_vld_q <= '0;
          for (int i = 0; i < DEPTH; i++) begin
            mem_data_q[i] <= '0;
          end
        end else begin
          mem_vld_q[ptr_q]  <= wr_vld_d;
          mem_data_q[ptr_q] <= wr_data_d;
        end
      end

      assign rd_vld  = mem_vld_q[ptr_q];
      assign rd_data = mem_data_q[ptr_q];
    end
  endgenerate

  // Invalid slots leave data_o untouched so the output bus stays quiet while idle.
  always_comb begin
    done_d = rd_vld;
    data_d = rd_vld ? rd_data : data_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      done_q <= 1'b0;
      data_q <= '0;
    end else begin
      done_q <= done_d;
      data_q <= data_d;
    end
  end

  assign done_o = done_q;
  assign data_o = data_q;

endmodule

// File: tb/tb_line_buffer.sv
// Directed bench for line_buffer: a DEPTH=5 and a DEPTH=1 instance checked every cycle
// against a queue-based delay model, plus hand-computed spot values.
module tb_line_buffer;

  logic       clk;
  logic       rst;
  logic       done5_i, done1_i;
  logic [7:0] data5_i, data1_i;
  logic       done5_o, done1_o;
  logic [7:0] data5_o, data1_o;

  int n_checks = 0;
  int n_fails  = 0;

  line_buffer #(.DATA_WIDTH(8), .DEPTH(5)) u_d5 (
    .clk(clk), .rst(rst), .done_i(done5_i), .data_i(data5_i),
    .data_o(data5_o), .done_o(done5_o)
  );

  line_buffer #(.DATA_WIDTH(8), .DEPTH(1)) u_d1 (
    .clk(clk), .rst(rst), .done_i(done1_i), .data_i(data1_i),
    .data_o(data1_o), .done_o(done1_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Model: output after an edge is whatever was accepted DEPTH edges earlier.
  logic [8:0] q5[$];
  logic [8:0] q1[$];
  logic [8:0] e5, e1;
  logic       exp_done5, exp_done1;
  logic [7:0] exp_data5, exp_data1;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      q5 = {};
      q1 = {};
      for (int i = 0; i < 5; i++) q5.push_back(9'h0);
      q1.push_back(9'h0);
      exp_done5 = 1'b0; exp_data5 = 8'h0;
      exp_done1 = 1'b0; exp_data1 = 8'h0;
    end else begin
      q5.push_back({done5_i, data5_i});
      e5 = q5.pop_front();
      exp_done5 = e5[8];
      if (e5[8]) exp_data5 = e5[7:0];
      q1.push_back({done1_i, data1_i});
      e1 = q1.pop_front();
      exp_done1 = e1[8];
      if (e1[8]) exp_data1 = e1[7:0];
    end
  end

  always @(negedge clk) begin
    if (q5.size() != 0) begin
      check("d5_done", {31'b0, done5_o}, {31'b0, exp_done5});
      check("d5_data", {24'b0, data5_o}, {24'b0, exp_data5});
      check("d1_done", {31'b0, done1_o}, {31'b0, exp_done1});
      check("d1_data", {24'b0, data1_o}, {24'b0, exp_data1});
    end
  end

  task automatic edge5(input logic v, input logic [7:0] d);
    done5_i = v;
    data5_i = d;
    @(posedge clk);
    #1;
  endtask

  logic       gap_v [12];
  logic [7:0] gap_d [12];
  int         hi_cnt;

  initial begin
    rst = 1'b1;
    done5_i = 1'b0; data5_i = 8'h0;
    done1_i = 1'b0; data1_i = 8'h0;
    #2 rst = 1'b0;

    // Test 1: reset one clock, then idle.
    @(posedge clk); #1;
    check("t1_rst_done", {31'b0, done5_o}, 32'd0);
    check("t1_rst_data", {24'b0, data5_o}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      edge5(1'b0, 8'h0);
      check("t1_idle_done", {31'b0, done5_o}, 32'd0);
      check("t1_idle_data", {24'b0, data5_o}, 32'd0);
    end

    // Test 2: contiguous burst 1..10.
    for (int e = 0; e < 20; e++) begin
      edge5(e < 10, (e < 10) ? 8'(e + 1) : 8'h0);
      if (e == 4)  check("t2_e4_done",  {31'b0, done5_o}, 32'd0);
      if (e == 5)  check("t2_e5_data",  {24'b0, data5_o}, 32'd1);
      if (e == 5)  check("t2_e5_done",  {31'b0, done5_o}, 32'd1);
      if (e == 14) check("t2_e14_data", {24'b0, data5_o}, 32'd10);
      if (e == 15) check("t2_e15_done", {31'b0, done5_o}, 32'd0);
      if (e == 15) check("t2_e15_data", {24'b0, data5_o}, 32'd10);
    end

    // Test 3: gapped input; idle cycles carry junk data that must never emerge.
    gap_v = '{1, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0};
    gap_d = '{8'd1, 8'd2, 8'hEE, 8'hEE, 8'd3, 8'd4, 8'hEE, 8'hEE, 8'hEE, 8'hEE, 8'hEE, 8'hEE};
    for (int e = 0; e < 12; e++) begin
      edge5(gap_v[e], gap_d[e]);
      if (e == 6) check("t3_e6_data", {24'b0, data5_o}, 32'd2);
      if (e == 7) check("t3_e7_done", {31'b0, done5_o}, 32'd0);
      if (e == 8) check("t3_e8_data", {24'b0, data5_o}, 32'd2);
      if (e == 9) check("t3_e9_data", {24'b0, data5_o}, 32'd3);
      if (e == 10) check("t3_e10_data", {24'b0, data5_o}, 32'd4);
    end

    // Test 4: reset after the 7th pixel of a burst.
    for (int e = 0; e < 7; e++) edge5(1'b1, 8'(e + 1));
    check("t4_pre_data", {24'b0, data5_o}, 32'd2);
    rst = 1'b0;
    #1;
    check("t4_rst_done", {31'b0, done5_o}, 32'd0);
    check("t4_rst_data", {24'b0, data5_o}, 32'd0);
    done5_i = 1'b0;
    data5_i = 8'h0;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 15; i++) begin
      edge5(1'b0, 8'h0);
      check("t4_after_done", {31'b0, done5_o}, 32'd0);
    end

    // Test 5: 17 consecutive pixels across three pointer wraps.
    for (int e = 0; e < 27; e++) begin
      edge5(e < 17, (e < 17) ? 8'(8'h10 + e) : 8'h0);
      if (e == 5)  check("t5_first", {24'b0, data5_o}, 32'h10);
      if (e == 12) check("t5_mid",   {24'b0, data5_o}, 32'h17);
      if (e == 21) check("t5_last",  {24'b0, data5_o}, 32'h20);
    end

    // Test 6: DEPTH = 1 burst.
    hi_cnt = 0;
    for (int e = 0; e < 8; e++) begin
      done1_i = (e < 3);
      data1_i = (e == 0) ? 8'hA5 : (e == 1) ? 8'h5A : (e == 2) ? 8'hFF : 8'h00;
      @(posedge clk);
      #1;
      if (done1_o) hi_cnt++;
      if (e == 0) check("t6_e0_done", {31'b0, done1_o}, 32'd0);
      if (e == 1) check("t6_e1_data", {24'b0, data1_o}, 32'hA5);
      if (e == 2) check("t6_e2_data", {24'b0, data1_o}, 32'h5A);
      if (e == 3) check("t6_e3_data", {24'b0, data1_o}, 32'hFF);
      if (e == 5) check("t6_e5_hold", {24'b0, data1_o}, 32'hFF);
    end
    check("t6_high_cycles", hi_cnt, 32'd3);

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
